// File: rtl/adc_pkg.sv
// Shared ADC front-end constants: divider defaults and the XADC DRP channel addresses
// used by the sampling controller.
package adc_pkg;

    localparam int ADC_CNT_W       = 16;
    localparam int ADC_DEFAULT_DIV = 4;
    localparam int ADC_MIN_DIV     = 2;

    // Auxiliary analog inputs: VAUX0 carries the switch channel, VAUX1 the feed channel.
    typedef enum logic [6:0] {
        DRP_VAUX0 = 7'h10,
        DRP_VAUX1 = 7'h11
    } drp_addr_e;

endpackage : adc_pkg

// File: rtl/adc_clk_divider.sv
// Divided ADC sample clock generator with a per-period tick and a glitch-free,
// wrap-aligned runtime reload of the divide ratio.
module adc_clk_divider
    import adc_pkg::*;
#(
    parameter int CNT_W       = ADC_CNT_W,
    parameter int DEFAULT_DIV = ADC_DEFAULT_DIV,
    parameter int MIN_DIV     = ADC_MIN_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             clk_enable,
    output logic             tick,
    output logic [CNT_W-1:0] ratio_active
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] pending_reg;
    logic [CNT_W-1:0] pending_next;
    logic [CNT_W-1:0] active_reg;
    logic [CNT_W-1:0] active_next;
    logic [CNT_W-1:0] cnt_wrapped;
    logic [CNT_W-1:0] load_val;
    logic             wrap;
    logic             clk_enable_reg;
    logic             clk_enable_next;
    logic             tick_reg;
    logic             tick_next;

    function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] r);
        return (r < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : r;
    endfunction

    // A period ends when cnt reaches the last slot of the ratio in force; a ratio
    // loaded on that same edge is forwarded so it already governs the next period.
    always_comb begin
        load_val        = clamp_ratio(div_ratio);
        wrap            = (cnt_reg == (active_reg - CNT_W'(1)));
        cnt_wrapped     = wrap ? '0 : (cnt_reg + CNT_W'(1));
        cnt_next        = cnt_reg;
        pending_next    = div_load ? load_val : pending_reg;
        active_next     = active_reg;
        clk_enable_next = clk_enable_reg;
        tick_next       = 1'b0;
        if (en) begin
            cnt_next        = cnt_wrapped;
            if (wrap) begin
                active_next = pending_next;
            end
            clk_enable_next = (cnt_wrapped < (active_next >> 1));
            tick_next       = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= CNT_W'(DEFAULT_DIV - 1);
            pending_reg <= CNT_W'(DEFAULT_DIV);
            active_reg  <= CNT_W'(DEFAULT_DIV);
        end else begin
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            active_reg  <= active_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_enable_reg <= 1'b0;
            tick_reg       <= 1'b0;
        end else begin
            clk_enable_reg <= clk_enable_next;
            tick_reg       <= tick_next;
        end
    end

    assign clk_enable   = clk_enable_reg;
    assign tick         = tick_reg;
    assign ratio_active = active_reg;

endmodule : adc_clk_divider

// File: tb/tb_adc_clk_divider.sv
// Self-checking bench for adc_clk_divider: a per-period waveform model plus directed
// literal patterns for each reload, enable and reset scenario.
module tb_adc_clk_divider;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] div_ratio;
    logic        div_load;
    logic        clk_enable;
    logic        tick;
    logic [15:0] ratio_active;

    int tests = 0;
    int fails = 0;

    logic [31:0] ce_v;
    logic [31:0] tk_v;

    // Model: a queue holding the remaining (clk_enable, tick) samples of the current period.
    logic [1:0] per_q[$];
    int         m_n       = 4;
    int         m_pend    = 4;
    logic       exp_ce    = 1'b0;
    logic       exp_tick  = 1'b0;

    adc_clk_divider dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div_ratio    (div_ratio),
        .div_load     (div_load),
        .clk_enable   (clk_enable),
        .tick         (tick),
        .ratio_active (ratio_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q.delete();
            m_n      = 4;
            m_pend   = 4;
            exp_ce   = 1'b0;
            exp_tick = 1'b0;
        end else begin
            logic [1:0] s;
            if (div_load) m_pend = (div_ratio < 16'd2) ? 2 : int'(div_ratio);
            if (en) begin
                if (per_q.size() == 0) begin
                    m_n = m_pend;
                    for (int i = 0; i < m_n; i++) per_q.push_back({(i < m_n / 2), (i == 0)});
                end
                s        = per_q.pop_front();
                exp_ce   = s[1];
                exp_tick = s[0];
            end else begin
                exp_tick = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_ce", 32'(clk_enable), 32'(exp_ce));
        check("model_tick", 32'(tick), 32'(exp_tick));
        check("model_ratio", 32'(ratio_active), 32'(m_n));
    end

    // One edge with the given inputs; the resulting outputs are shifted into ce_v/tk_v.
    task automatic cyc(input logic en_v, input logic load_v, input logic [15:0] ratio_v);
        en        = en_v;
        div_load  = load_v;
        div_ratio = ratio_v;
        @(posedge clk);
        #1;
        ce_v = {ce_v[30:0], clk_enable};
        tk_v = {tk_v[30:0], tick};
        $display("[TB] t=%0t en=%0b load=%0b ratio=%0d -> clk_enable=%0b tick=%0b active=%0d",
                 $time, en_v, load_v, ratio_v, clk_enable, tick, ratio_active);
    endtask

    task automatic clr();
        ce_v = '0;
        tk_v = '0;
    endtask

    logic [15:0] sweep_ratios [6];

    initial begin
        en        = 1'b0;
        div_load  = 1'b0;
        div_ratio = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ce", 32'(clk_enable), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_ratio", 32'(ratio_active), 32'd4);
        rst_n = 1'b1;

        // Default ratio 4
        clr();
        repeat (8) cyc(1'b1, 1'b0, 16'd0);
        check("t1_ce", ce_v, 32'b11001100);
        check("t1_tick", tk_v, 32'b10001000);
        check("t1_ratio", 32'(ratio_active), 32'd4);

        // Mid-period load of 5
        clr();
        cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd5);
        repeat (2) cyc(1'b1, 1'b0, 16'd0);
        check("t2_ratio_old", 32'(ratio_active), 32'd4);
        repeat (5) cyc(1'b1, 1'b0, 16'd0);
        check("t2_ce", ce_v, 32'b110011000);
        check("t2_tick", tk_v, 32'b100010000);
        check("t2_ratio", 32'(ratio_active), 32'd5);

        // Loads of 0 then 1, both clamped to 2
        clr();
        cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd0);
        cyc(1'b1, 1'b1, 16'd1);
        repeat (2) cyc(1'b1, 1'b0, 16'd0);
        check("t3_ratio_old", 32'(ratio_active), 32'd5);
        repeat (4) cyc(1'b1, 1'b0, 16'd0);
        check("t3_ce", ce_v, 32'b110001010);
        check("t3_tick", tk_v, 32'b100001010);
        check("t3_ratio", 32'(ratio_active), 32'd2);

        // Back to 4, then en low for 3 cycles mid-period
        clr();
        cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd4);
        repeat (2) cyc(1'b1, 1'b0, 16'd0);
        repeat (3) cyc(1'b0, 1'b0, 16'd0);
        repeat (3) cyc(1'b1, 1'b0, 16'd0);
        check("t4_ce", ce_v, 32'b1011111001);
        check("t4_tick", tk_v, 32'b1010000001);

        // Load 6 on the exact wrap edge
        clr();
        repeat (3) cyc(1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 16'd6);
        repeat (6) cyc(1'b1, 1'b0, 16'd0);
        check("t5_ce", ce_v, 32'b1001110001);
        check("t5_tick", tk_v, 32'b0001000001);
        check("t5_ratio", 32'(ratio_active), 32'd6);

        // Asynchronous reset between edges, right after a tick
        #2 rst_n = 1'b0;
        #1;
        check("t6_ce_async", 32'(clk_enable), 32'd0);
        check("t6_tick_async", 32'(tick), 32'd0);
        check("t6_ratio_async", 32'(ratio_active), 32'd4);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        repeat (8) cyc(1'b1, 1'b0, 16'd0);
        check("t6_ce", ce_v, 32'b11001100);
        check("t6_tick", tk_v, 32'b10001000);
        check("t6_ratio", 32'(ratio_active), 32'd4);

        // Deterministic sweep of loads and enable gaps, checked by the model
        sweep_ratios[0] = 16'd3;
        sweep_ratios[1] = 16'd7;
        sweep_ratios[2] = 16'd1;
        sweep_ratios[3] = 16'd0;
        sweep_ratios[4] = 16'd2;
        sweep_ratios[5] = 16'd9;
        for (int i = 0; i < 54; i++) begin
            cyc(((i % 7) != 3), ((i % 9) == 4) || ((i % 9) == 6), sweep_ratios[i / 9]);
        end
        cyc(1'b1, 1'b0, 16'd0);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_adc_clk_divider
